// File: rtl/uart_pkg.sv
// Shared UART definitions: register offsets, STATUS bit positions and FSM state types.
package uart_pkg;

  localparam logic [4:0] OFFSET0 = 5'd0;  // RXDATA
  localparam logic [4:0] OFFSET1 = 5'd4;  // TXDATA
  localparam logic [4:0] OFFSET2 = 5'd8;  // STATUS

  localparam int unsigned STATUS_RRDY = 7;
  localparam int unsigned STATUS_TRDY = 6;
  localparam int unsigned STATUS_ROE  = 3;
  localparam int unsigned STATUS_FE   = 2;

  typedef enum logic [1:0] {TxIdle, TxStart, TxData, TxStop} tx_state_e;
  typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;

  function automatic logic [31:0] pack_status(input logic rrdy, input logic trdy,
                                              input logic roe, input logic fe);
    logic [31:0] s;
    s              = '0;
    s[STATUS_RRDY] = rrdy;
    s[STATUS_TRDY] = trdy;
    s[STATUS_ROE]  = roe;
    s[STATUS_FE]   = fe;
    return s;
  endfunction

endpackage

// File: rtl/uart_rx_core.sv
// UART receiver: 2-flop input synchronizer, mid-bit sampling FSM, byte-valid and
// framing-error pulses (one cycle each).
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int unsigned CLK_PER_BIT = 434
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_rxd,
  output logic       o_valid,
  output logic [7:0] o_data,
  output logic       o_fe
);

  localparam int unsigned    BW       = $clog2(CLK_PER_BIT);
  localparam logic [BW-1:0] BaudLast = BW'(CLK_PER_BIT - 1);
  localparam logic [BW-1:0] BaudHalf = BW'(CLK_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] BaudOne  = BW'(1);

  logic [1:0]    sync_q, sync_d;
  logic          prev_q, prev_d;
  rx_state_e     state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          valid_q, valid_d;
  logic          fe_q, fe_d;
  logic          rx_s;

  assign rx_s    = sync_q[1];
  assign o_valid = valid_q;
  assign o_data  = shift_q;
  assign o_fe    = fe_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sync_q  <= 2'b11;
      prev_q  <= 1'b1;
      state_q <= RxIdle;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      valid_q <= 1'b0;
      fe_q    <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      prev_q  <= prev_d;
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      valid_q <= valid_d;
      fe_q    <= fe_d;
    end
  end

  always_comb begin
    sync_d  = {sync_q[0], i_rxd};
    prev_d  = rx_s;
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    valid_d = 1'b0;
    fe_d    = 1'b0;
    unique case (state_q)
      RxIdle: begin
        // A falling edge only re-arms after the line has been seen high, which
        // also covers waiting out a low line after a framing error.
        if (prev_q && !rx_s) begin
          state_d = RxStart;
          baud_d  = '0;
        end
      end
      RxStart: begin
        if (baud_q == BaudHalf) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = rx_s ? RxIdle : RxData;
        end else begin
          baud_d = baud_q + BaudOne;
        end
      end
      RxData: begin
        if (baud_q == BaudLast) begin
          baud_d  = '0;
          shift_d = {rx_s, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = RxStop;
        end else begin
          baud_d = baud_q + BaudOne;
        end
      end
      RxStop: begin
        if (baud_q == BaudLast) begin
          baud_d  = '0;
          state_d = RxIdle;
          valid_d = rx_s;
          fe_d    = !rx_s;
        end else begin
          baud_d = baud_q + BaudOne;
        end
      end
      default: state_d = RxIdle;
    endcase
  end

endmodule

// File: rtl/uart_mm_slave.sv
// Memory-mapped UART with RXDATA/TXDATA/STATUS registers and double-buffered TX.
// Define UART_LOOPBACK_EN to feed the TX stream into RX internally (o_txd held high).
module uart_mm_slave
  import uart_pkg::*;
#(
  parameter int unsigned CLK_PER_BIT = 434
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [4:0]  i_address,
  input  logic        i_read,
  output logic [31:0] o_readdata,
  input  logic        i_write,
  input  logic [31:0] i_writedata,
  output logic        o_waitrequest,
  input  logic        i_rxd,
  output logic        o_txd
);

  localparam int unsigned    BW       = $clog2(CLK_PER_BIT);
  localparam logic [BW-1:0] BaudLast = BW'(CLK_PER_BIT - 1);
  localparam logic [BW-1:0] BaudOne  = BW'(1);

  logic          ack_q, ack_d;
  logic [31:0]   readdata_q, readdata_d;
  logic [7:0]    rxdata_q, rxdata_d;
  logic          rrdy_q, rrdy_d;
  logic          roe_q, roe_d;
  logic          fe_q, fe_d;
  logic          trdy_q, trdy_d;
  logic [7:0]    thr_q, thr_d;
  tx_state_e     tx_state_q, tx_state_d;
  logic [BW-1:0] tx_baud_q, tx_baud_d;
  logic [2:0]    tx_bit_q, tx_bit_d;
  logic [7:0]    tx_shift_q, tx_shift_d;
  logic          txd_q, txd_d;

  logic          access, stall, accept, is_rd, is_wr;
  logic [31:0]   rd_mux;
  logic          rx_in, rx_valid, rx_fe;
  logic [7:0]    rx_byte;
  logic          unused_wdata;

  assign unused_wdata = ^i_writedata[31:8];

`ifdef UART_LOOPBACK_EN
  logic unused_rxd;
  assign unused_rxd = i_rxd;
  assign rx_in      = txd_q;
  assign o_txd      = 1'b1;
`else
  assign rx_in = i_rxd;
  assign o_txd = txd_q;
`endif

  assign access        = i_read | i_write;
  assign stall         = access & ~ack_q;
  assign accept        = access & ack_q;
  assign is_rd         = i_read;
  assign is_wr         = i_write & ~i_read;
  assign o_waitrequest = stall;
  assign o_readdata    = readdata_q;
  assign ack_d         = stall;

  uart_rx_core #(
    .CLK_PER_BIT(CLK_PER_BIT)
  ) u_rx (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_rxd  (rx_in),
    .o_valid(rx_valid),
    .o_data (rx_byte),
    .o_fe   (rx_fe)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ack_q      <= 1'b0;
      readdata_q <= '0;
      rxdata_q   <= '0;
      rrdy_q     <= 1'b0;
      roe_q      <= 1'b0;
      fe_q       <= 1'b0;
      trdy_q     <= 1'b1;
      thr_q      <= '0;
      tx_state_q <= TxIdle;
      tx_baud_q  <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      txd_q      <= 1'b1;
    end else begin
      ack_q      <= ack_d;
      readdata_q <= readdata_d;
      rxdata_q   <= rxdata_d;
      rrdy_q     <= rrdy_d;
      roe_q      <= roe_d;
      fe_q       <= fe_d;
      trdy_q     <= trdy_d;
      thr_q      <= thr_d;
      tx_state_q <= tx_state_d;
      tx_baud_q  <= tx_baud_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      txd_q      <= txd_d;
    end
  end

  always_comb begin
    rd_mux = '0;
    case (i_address)
      OFFSET0: rd_mux = {24'b0, rxdata_q};
      OFFSET2: rd_mux = pack_status(rrdy_q, trdy_q, roe_q, fe_q);
      default: rd_mux = '0;
    endcase
  end

  // Read data is captured in the stall cycle; side effects wait for the accept cycle.
  always_comb begin
    readdata_d = (stall && is_rd) ? rd_mux : readdata_q;
    rxdata_d   = rxdata_q;
    rrdy_d     = rrdy_q;
    roe_d      = roe_q;
    fe_d       = fe_q;
    if (accept && is_rd && (i_address == OFFSET0)) rrdy_d = 1'b0;
    if (accept && is_wr && (i_address == OFFSET2)) begin
      roe_d = 1'b0;
      fe_d  = 1'b0;
    end
    if (rx_valid) begin
      rxdata_d = rx_byte;
      rrdy_d   = 1'b1;
      if (rrdy_q) roe_d = 1'b1;
    end
    if (rx_fe) fe_d = 1'b1;
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_baud_d  = tx_baud_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    txd_d      = txd_q;
    trdy_d     = trdy_q;
    thr_d      = thr_q;
    // Writes while the holding register is full are silently dropped.
    if (accept && is_wr && (i_address == OFFSET1) && trdy_q) begin
      thr_d  = i_writedata[7:0];
      trdy_d = 1'b0;
    end
    unique case (tx_state_q)
      TxIdle: begin
        if (!trdy_q) begin
          tx_shift_d = thr_q;
          trdy_d     = 1'b1;
          tx_baud_d  = '0;
          tx_state_d = TxStart;
          txd_d      = 1'b0;
        end
      end
      TxStart: begin
        if (tx_baud_q == BaudLast) begin
          tx_baud_d  = '0;
          tx_bit_d   = '0;
          tx_state_d = TxData;
          txd_d      = tx_shift_q[0];
        end else begin
          tx_baud_d = tx_baud_q + BaudOne;
        end
      end
      TxData: begin
        if (tx_baud_q == BaudLast) begin
          tx_baud_d = '0;
          if (tx_bit_q == 3'd7) begin
            tx_state_d = TxStop;
            txd_d      = 1'b1;
          end else begin
            tx_bit_d   = tx_bit_q + 3'd1;
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
            txd_d      = tx_shift_q[1];
          end
        end else begin
          tx_baud_d = tx_baud_q + BaudOne;
        end
      end
      TxStop: begin
        if (tx_baud_q == BaudLast) begin
          tx_baud_d  = '0;
          tx_state_d = TxIdle;
        end else begin
          tx_baud_d = tx_baud_q + BaudOne;
        end
      end
      default: tx_state_d = TxIdle;
    endcase
  end

endmodule

// File: tb/tb_uart_mm_slave.sv
// Scoreboard bench for uart_mm_slave at CLK_PER_BIT=16: reads push expected data,
// a forked monitor pops and compares whenever a read is accepted.
module tb_uart_mm_slave;

  localparam int CPB = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  i_address;
  logic        i_read;
  logic [31:0] o_readdata;
  logic        i_write;
  logic [31:0] i_writedata;
  logic        o_waitrequest;
  logic        i_rxd;
  logic        o_txd;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_q[$];
  int          lead;

  always #5 clk = ~clk;

  uart_mm_slave #(
    .CLK_PER_BIT(CPB)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_address    (i_address),
    .i_read       (i_read),
    .o_readdata   (o_readdata),
    .i_write      (i_write),
    .i_writedata  (i_writedata),
    .o_waitrequest(o_waitrequest),
    .i_rxd        (i_rxd),
    .o_txd        (o_txd)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (i_read && !o_waitrequest) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL rd_unexpected: got 0x%08h expected no read", o_readdata);
        end else begin
          check("readdata", o_readdata, exp_q.pop_front());
        end
      end
    end
  endtask

  // Called at the start of a cycle; returns at the start of the cycle after accept.
  task automatic bus_access(input logic rd, input logic [4:0] addr, input logic [31:0] wdata,
                            input logic [31:0] exp);
    int stalls;
    bit done;
    stalls = 0;
    done   = 1'b0;
    if (rd) exp_q.push_back(exp);
    i_address   = addr;
    i_read      = rd;
    i_write     = !rd;
    i_writedata = wdata;
    for (int i = 0; i < 8 && !done; i++) begin
      @(negedge clk);
      if (o_waitrequest) stalls++;
      else done = 1'b1;
    end
    if (done) begin
      check("stall_cycles", 32'(stalls), 32'd1);
    end else begin
      checks++;
      failures++;
      $display("FAIL bus_timeout: got waitrequest stuck expected release");
      if (rd) void'(exp_q.pop_back());
    end
    @(posedge clk);
    #1;
    i_read  = 1'b0;
    i_write = 1'b0;
  endtask

  task automatic rd(input logic [4:0] addr, input logic [31:0] exp);
    bus_access(1'b1, addr, 32'h0, exp);
  endtask

  task automatic wr(input logic [4:0] addr, input logic [31:0] data);
    bus_access(1'b0, addr, data, 32'h0);
  endtask

  // Waits for the start bit, then checks every sample of all ten bit periods.
  task automatic check_tx_frame(input logic [7:0] data, output int lead_o);
    logic [9:0] frame;
    int errs;
    bit found;
    frame  = {1'b1, data, 1'b0};
    lead_o = 0;
    found  = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge clk);
      lead_o++;
      if (o_txd === 1'b0) found = 1'b1;
    end
    if (!found) begin
      checks++;
      failures++;
      $display("FAIL tx_no_start: got txd high expected start bit");
      return;
    end
    for (int b = 0; b < 10; b++) begin
      errs = 0;
      for (int s = 0; s < CPB; s++) begin
        if (b != 0 || s != 0) @(negedge clk);
        if (o_txd !== frame[b]) errs++;
      end
      check($sformatf("tx_%02h_bit%0d_bad_samples", data, b), 32'(errs), 32'd0);
    end
  endtask

  task automatic send_rx(input logic [7:0] data, input logic stop);
    logic [9:0] f;
    f = {stop, data, 1'b0};
    for (int b = 0; b < 10; b++) begin
      i_rxd = f[b];
      repeat (CPB) @(posedge clk);
      #1;
    end
    i_rxd = 1'b1;
  endtask

  initial begin
    rst         = 1'b1;
    i_read      = 1'b0;
    i_write     = 1'b0;
    i_address   = '0;
    i_writedata = '0;
    i_rxd       = 1'b1;
    fork
      monitor();
    join_none
    repeat (3) @(posedge clk);
    #1;
    check("reset_txd", 32'(o_txd), 32'd1);
    check("reset_readdata", o_readdata, 32'h0);
    check("reset_waitrequest", 32'(o_waitrequest), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    rd(5'd8, 32'h40);
    check("idle_txd", 32'(o_txd), 32'd1);
    rd(5'd12, 32'h0);
    wr(5'd12, 32'hFFFF_FFFF);
    rd(5'd8, 32'h40);

    // TX 0xA5; meanwhile check TRDY timing and that a write with TRDY=0 is dropped
    wr(5'd4, 32'h0000_00A5);
    fork
      begin
        check_tx_frame(8'hA5, lead);
        check("tx_start_latency", 32'(lead), 32'd2);
        check_tx_frame(8'h01, lead);
      end
      begin
        rd(5'd8, 32'h00);
        rd(5'd8, 32'h40);
        wr(5'd4, 32'h01);
        wr(5'd4, 32'h02);
        rd(5'd8, 32'h00);
      end
    join
    repeat (4) @(posedge clk);
    #1;
    rd(5'd8, 32'h40);

    // RX single byte
    send_rx(8'h3C, 1'b1);
    rd(5'd8, 32'hC0);
    rd(5'd0, 32'h3C);
    rd(5'd8, 32'h40);

    // Overrun
    send_rx(8'h11, 1'b1);
    send_rx(8'h22, 1'b1);
    rd(5'd8, 32'hC8);
    rd(5'd0, 32'h22);
    wr(5'd8, 32'h0);
    rd(5'd8, 32'h40);

    // Framing error
    send_rx(8'h55, 1'b0);
    rd(5'd8, 32'h44);
    wr(5'd8, 32'hFF);
    rd(5'd8, 32'h40);

    // Short glitch is rejected, and the receiver still works afterwards
    i_rxd = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    i_rxd = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    rd(5'd8, 32'h40);
    send_rx(8'h5A, 1'b1);
    rd(5'd0, 32'h5A);

    // Reset during a TX frame
    wr(5'd4, 32'h00);
    repeat (50) @(posedge clk);
    #1;
    check("txd_mid_frame", 32'(o_txd), 32'd0);
    rst = 1'b1;
    #1;
    check("txd_async_reset", 32'(o_txd), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    rd(5'd8, 32'h40);
    repeat (20) @(posedge clk);
    #1;
    check("txd_after_reset", 32'(o_txd), 32'd1);

    repeat (3) @(posedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_mm_slave.md
UART_MM_SLAVE -- requirements
Module: uart_mm_slave

Interface
REQ-001 SHALL have parameter CLK_PER_BIT, default 434, meaning i_clk cycles per serial bit (50 MHz / 115200); legal range 8..65535.
REQ-002 SHALL have one clock; reset is asynchronous and active-high. Ports: i_clk  in  1  rising-edge clock.
REQ-003 SHALL have i_rst  in  1  asynchronous, active-high reset.
REQ-004 SHALL have i_address  in  5  byte offset of the register access.
REQ-005 SHALL have i_read  in  1  read strobe, held until o_waitrequest is low.
REQ-006 SHALL have o_readdata  out  32  read data, valid in the cycle o_waitrequest is low.
REQ-007 SHALL have i_write  in  1  write strobe, held until o_waitrequest is low.
REQ-008 SHALL have i_writedata  in  32  write data.
REQ-009 SHALL have o_waitrequest  out  1  stall for the current access.
REQ-010 SHALL have i_rxd  in  1  serial input, idle high.
REQ-011 SHALL have o_txd  out  1  serial output, idle high.

Function
REQ-012 SHALL map registers: 0 RXDATA (R, bits[7:0]); 4 TXDATA (W, bits[7:0]); 8 STATUS (R/W): bit7 RRDY, bit6 TRDY, bit3 ROE, bit2 FE; all other bits read 0.
REQ-013 SHALL complete every access in exactly 2 cycles: o_waitrequest = (i_read|i_write) & ~ack_r; ack_r sets on the first cycle and clears on the next. Back-to-back held strobes give 1 stall cycle plus 1 accept cycle, repeating.
REQ-014 SHALL register o_readdata in the stall cycle. Side effects (RRDY clear, TXDATA load, flag clear) SHALL occur at the end of the accept cycle only.
REQ-015 SHALL return 0 for reads of unmapped offsets and ignore writes to them. i_read and i_write both high SHALL be treated as a read.
REQ-016 SHALL clear RRDY on an RXDATA read. If the receiver completes a byte in the same cycle, set wins and the read returns the old byte.
REQ-017 SHALL load the TX holding register and clear TRDY on a TXDATA write while TRDY=1. A write while TRDY=0 SHALL be dropped without error.
REQ-018 SHALL clear ROE and FE on any STATUS write; the written data is ignored.
REQ-019 SHALL implement a TX FSM with states IDLE, START, DATA, STOP:
  - IDLE with holding register full -> move the byte to the shifter and set TRDY (double buffered).
  - Frame is start 0, 8 data bits LSB first, stop 1, each CLK_PER_BIT cycles; 10*CLK_PER_BIT cycles per frame.
  - o_txd SHALL go low on the cycle after the FSM leaves IDLE.
REQ-020 SHALL pass i_rxd through a 2-flop synchronizer before all RX logic.
REQ-021 SHALL implement an RX FSM with states IDLE, START, DATA, STOP:
  - Falling edge -> START.
  - Sample at CLK_PER_BIT/2; if high, treat as a glitch and return to IDLE.
  - DATA samples 8 bits mid-bit, LSB first.
  - STOP sampled high -> store byte to RXDATA and set RRDY; if RRDY was already 1, overwrite and set ROE.
  - STOP sampled low -> discard the byte, set FE, and wait for the line to go high before re-arming.
REQ-022 SHALL keep baud and bit counters sized by $clog2(CLK_PER_BIT) and 3 bits, wrapping only on bit boundaries.

Reset
REQ-023 SHALL on i_rst (async assert, sync release) force o_txd=1, o_readdata=0, ack_r=0, TRDY=1, RRDY=ROE=FE=0, both FSMs IDLE, and all counters and data registers 0.
REQ-024 SHALL abort any frame in progress on reset mid-frame with no partial byte stored; o_txd SHALL return high immediately.

Configuration
REQ-025 SHALL support macro UART_LOOPBACK_EN. When defined, the RX input is the internal TX serial stream, i_rxd is ignored, and o_txd is held 1. When undefined, normal pins are used.

Structure
REQ-026 SHALL take from shared package uart_pkg: register offsets (OFFSET0/OFFSET1/OFFSET2 = 0/4/8), STATUS bit index constants, and TX/RX state enum typedefs.
REQ-027 SHALL instantiate sub-module uart_rx_core (synchronizer, RX FSM, byte-valid and framing-error pulses); TX and register logic SHALL stay in uart_mm_slave.

Verification (CLK_PER_BIT=16)
REQ-028 SHALL check: reset, then read STATUS -> 0x40, o_waitrequest high 1 cycle then low, o_txd=1.
REQ-029 SHALL check: write TXDATA 0xA5 -> o_txd low 16 cycles, then 1,0,1,0,0,1,0,1, then high; TRDY=1 two cycles after the write.
REQ-030 SHALL check: drive 0x3C on i_rxd -> STATUS=0xC0 after the stop bit; RXDATA read returns 0x3C, then STATUS=0x40.
REQ-031 SHALL check: two frames 0x11, 0x22 with no read -> RXDATA=0x22, ROE=1; STATUS write -> ROE=0.
REQ-032 SHALL check: frame with stop bit 0 -> FE=1, RRDY=0; a 4-cycle low glitch -> no state change.
REQ-033 SHALL check: i_rst asserted mid TX frame -> o_txd=1 the same cycle, STATUS=0x40 after release.
